// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state encoding, SEL_ALL byte-select constant and word-address helper for wb_blkcopy
package wb_pkg;
  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, FIN} state_t;
  localparam logic [3:0] SEL_ALL = 4'hF;
  function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [31:0] idx);
    return (base & 32'hFFFF_FFFC) + (idx << 2);
  endfunction
endpackage

// File: rtl/wb_blkcopy_wdog.sv
// wb_blkcopy_wdog: bus-cycle watchdog (sys_clk, sys_rst_n, stb, ack=ack|err in; tmo out when stb has waited TIMEOUT cycles)
module wb_blkcopy_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic stb,
  input  logic ack,
  output logic tmo
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign tmo = stb && !ack && cnt == W'(TIMEOUT - 1);
  always_ff @(posedge sys_clk) cnt <= (!sys_rst_n || !stb || ack) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/wb_blkcopy.sv
// wb_blkcopy: Wishbone classic word block copier (start/src_adr/dst_adr/len in, busy/done/err out, wb_* master); WB_BLKCOPY_TIMEOUT_EN adds a per-cycle watchdog
module wb_blkcopy
  import wb_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);
  state_t state;
  logic [31:0] src, dst;
  logic [LEN_W-1:0] n, i;
  logic tmo, fail;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
`ifdef WB_BLKCOPY_TIMEOUT_EN
  wb_blkcopy_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .stb      (wb_stb_o),
    .ack      (wb_ack_i || wb_err_i),
    .tmo      (tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  assign fail = wb_err_i || tmo;
  // wb_dat_o doubles as the data register between the read and the write
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      {busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o} <= '0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          src <= src_adr;
          dst <= dst_adr;
          n <= len;
          i <= '0;
          err <= 1'b0;
          busy <= 1'b1;
          state <= (len == '0) ? FIN : RD;
          {wb_cyc_o, wb_stb_o} <= {2{len != '0}};
          wb_we_o <= 1'b0;
          wb_sel_o <= (len == '0) ? 4'h0 : SEL_ALL;
          wb_adr_o <= word_adr(src_adr, '0);
        end
        RD, WR: if (fail || wb_ack_i) begin
          {wb_cyc_o, wb_stb_o, wb_we_o} <= '0;
          wb_sel_o <= '0;
          if (fail) begin
            err <= 1'b1;
            state <= FIN;
          end else if (state == RD) begin
            wb_dat_o <= wb_dat_i;
            state <= RGAP;
          end else begin
            i <= i + 1'b1;
            state <= WGAP;
          end
        end
        RGAP: begin
          state <= WR;
          {wb_cyc_o, wb_stb_o, wb_we_o} <= '1;
          wb_sel_o <= SEL_ALL;
          wb_adr_o <= word_adr(dst, 32'(i));
        end
        WGAP: if (i < n) begin
          state <= RD;
          {wb_cyc_o, wb_stb_o} <= 2'b11;
          wb_sel_o <= SEL_ALL;
          wb_adr_o <= word_adr(src, 32'(i));
        end else state <= FIN;
        FIN: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_blkcopy.sv
// tb_wb_blkcopy: directed and randomized copies against a memory-slave model with wait states, error and hang injection
module tb_wb_blkcopy;
  logic sys_clk = 0, sys_rst_n = 0, start = 0;
  logic [31:0] src_adr = 0, dst_adr = 0, wb_dat_i = 0;
  logic [15:0] len = 0;
  logic busy, done, err, wb_stb_o, wb_cyc_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  logic wb_ack_i = 0, wb_err_i = 0;
  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  int busy_n = 0, done_n = 0, cyc_seen = 0, stb_n = 0, sel_bad = 0;
  int ws = 0, err_rd = 0, rd_n = 0, wcnt = 0;
  bit hang = 0;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} txn_t;
  txn_t log_q[$];
  logic [31:0] mem [logic [31:0]];

  wb_blkcopy #(.LEN_W(16), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
    .len(len), .busy(busy), .done(done), .err(err), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  function automatic logic [31:0] rdval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] wadr(input logic [31:0] base, input int k);
    longint w;
    w = ((longint'(base) >> 2) + k) % (longint'(1) << 30);
    return 32'(w * 4);
  endfunction

  // Slave responds and monitors on the falling edge so ack/err are stable at the next rising edge
  always @(negedge sys_clk) begin
    if (busy) busy_n++;
    if (done) done_n++;
    if (wb_cyc_o) cyc_seen++;
    if (wb_stb_o) stb_n++;
    if (wb_sel_o !== (wb_stb_o ? 4'hF : 4'h0)) sel_bad++;
    wb_ack_i = 0;
    wb_err_i = 0;
    if (!(wb_cyc_o && wb_stb_o)) wcnt = 0;
    else begin
      wcnt++;
      if (!hang && wcnt > ws) begin
        wcnt = 0;
        if (!wb_we_o) rd_n++;
        if (!wb_we_o && rd_n == err_rd) wb_err_i = 1;
        else begin
          wb_ack_i = 1;
          if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
          else wb_dat_i = rdval(wb_adr_o);
          log_q.push_back('{wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
    log_q.delete();
    busy_n = 0; done_n = 0; cyc_seen = 0; stb_n = 0; rd_n = 0;
    @(negedge sys_clk);
    src_adr = s; dst_adr = d; len = 16'(n); start = 1; t0 = cyc;
    @(negedge sys_clk);
    start = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic copy_test(input string tag, input logic [31:0] s, input logic [31:0] d, input int n, input int w);
    logic [31:0] expd[$];
    int lat;
    ws = w;
    for (int k = 0; k < n; k++) expd.push_back(rdval(wadr(s, k)));
    kick(s, d, n);
    wait_done(lat);
    repeat (2) @(negedge sys_clk);
    chk({tag, "_latency"}, lat, n == 0 ? 2 : n * (2 * (w + 1) + 2) + 2);
    chk({tag, "_ntxn"}, log_q.size(), 2 * n);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_err"}, err, 0);
    for (int k = 0; k < n; k++)
      if (2 * k + 1 < log_q.size()) begin
        chk({tag, "_rd"}, {log_q[2*k].we, log_q[2*k].adr, log_q[2*k].dat}, {1'b0, wadr(s, k), expd[k]});
        chk({tag, "_wr"}, {log_q[2*k+1].we, log_q[2*k+1].adr, log_q[2*k+1].dat}, {1'b1, wadr(d, k), expd[k]});
      end
  endtask

  initial begin
    int lat;
    bit found;
    repeat (3) @(negedge sys_clk);
    chk("reset_outputs", {busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 0);
    sys_rst_n = 1;
    copy_test("basic3_ws1", 32'h1000, 32'h2000, 3, 1);
    copy_test("len0", 32'h1100, 32'h2100, 0, 0);
    chk("len0_cyc_cycles", cyc_seen, 0);
    chk("len0_busy_cycles", busy_n, 1);
    copy_test("wrap", 32'hFFFF_FFFC, 32'h3000, 2, 0);
    ws = 0;
    err_rd = 2;
    kick(32'h4000, 32'h4800, 4);
    @(negedge sys_clk);
    src_adr = 32'h5000; len = 16'd1; start = 1;
    @(negedge sys_clk);
    start = 0;
    wait_done(lat);
    chk("buserr_latency", lat, 7);
    chk("buserr_err", err, 1);
    repeat (6) @(negedge sys_clk);
    chk("buserr_done_pulses", done_n, 1);
    chk("buserr_ntxn", log_q.size(), 2);
    chk("buserr_writes", (log_q.size() > 1) ? log_q[1].we : 1'b0, 1);
    chk("buserr_idle_after", {busy, wb_cyc_o}, 0);
    chk("buserr_err_sticky", err, 1);
    err_rd = 0;
`ifdef WB_BLKCOPY_TIMEOUT_EN
    hang = 1;
    kick(32'h6000, 32'h6800, 1);
    wait_done(lat);
    chk("timeout_err", err, 1);
    repeat (2) @(negedge sys_clk);
    chk("timeout_stb_cycles", stb_n, 8);
    chk("timeout_done_pulses", done_n, 1);
    chk("timeout_ntxn", log_q.size(), 0);
    hang = 0;
`endif
    ws = 3;
    kick(32'h7000, 32'h7800, 5);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (wb_stb_o && wb_we_o) found = 1;
      else @(negedge sys_clk);
    end
    chk("rstmid_reached_wr", found, 1);
    sys_rst_n = 0;
    @(negedge sys_clk);
    chk("rstmid_outputs", {busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 0);
    sys_rst_n = 1;
    repeat (3) @(negedge sys_clk);
    chk("rstmid_no_done", done_n, 0);
    copy_test("after_rst", 32'h7100, 32'h7900, 1, 0);
    for (int r = 0; r < 6; r++)
      copy_test("random", 32'h1000_0000 | ($urandom & 32'h00FF_FFFF), 32'h2000_0000 | ($urandom & 32'h00FF_FFFF),
                $urandom_range(1, 8), $urandom_range(0, 2));
    chk("sel_rule_violations", sel_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/wb_blkcopy.md
WB_BLKCOPY -- requirements
Module: wb_blkcopy

Interface
REQ-001 SHALL have parameter LEN_W, default 16, giving the width of the word-count input.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the cycles allowed per bus cycle before abort (used only with WB_BLKCOPY_TIMEOUT_EN).
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a copy.
REQ-006 SHALL have port src_adr  input  32  byte address of first source word; bits [1:0] ignored.
REQ-007 SHALL have port dst_adr  input  32  byte address of first destination word; bits [1:0] ignored.
REQ-008 SHALL have port len  input  LEN_W  number of 32-bit words to copy.
REQ-009 SHALL have port busy  output  1  high while a copy is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at copy end (success or abort).
REQ-011 SHALL have port err  output  1  sticky abort flag, cleared by the next accepted start.
REQ-012 SHALL have Wishbone classic master ports wb_adr_o[31:0], wb_dat_o[31:0], wb_dat_i[31:0], wb_sel_o[3:0], wb_stb_o, wb_cyc_o, wb_we_o (out), wb_ack_i and wb_err_i (in).

Function
REQ-013 SHALL latch src_adr, dst_adr and len on start while in IDLE; start at any other time is ignored.
REQ-014 SHALL implement states IDLE, RD, RGAP, WR, WGAP, FIN.
REQ-015 SHALL transition IDLE->RD on start with len!=0, and IDLE->FIN on start with len==0, issuing no bus cycle.
REQ-016 In RD, SHALL assert cyc=stb=1 and we=0, with adr={src[31:2]+i,2'b00}; on ack, SHALL capture wb_dat_i into the data register and move to RGAP.
REQ-017 In WR, SHALL assert cyc=stb=we=1, with adr={dst[31:2]+i,2'b00} and dat_o=data register; on ack, SHALL increment i and move to WGAP.
REQ-018 In RGAP and WGAP, SHALL deassert cyc and stb for exactly one cycle; RGAP->WR; WGAP->RD if i<len, else FIN.
REQ-019 SHALL drive wb_sel_o to 4'hF whenever stb is high, and 4'h0 otherwise.
REQ-020 SHALL hold adr, dat_o and we stable while stb is high until ack or err.
REQ-021 SHALL compute word indices modulo 2^30, so addresses wrap past 0xFFFFFFFC to 0x00000000.
REQ-022 SHALL, on wb_err_i in RD or WR, drop cyc and stb the next cycle, set err=1 and go to FIN; if ack and err are simultaneous, err wins.
REQ-023 In FIN, SHALL pulse done for one cycle and return to IDLE; busy SHALL be high in every state except IDLE.
REQ-024 SHALL have a total latency for N words with 0-wait-state acks of 4N+2 cycles from start to done.

Reset
REQ-025 On sys_rst_n=0 at a clock edge, SHALL force state=IDLE and busy=done=err=0, with wb_stb_o=wb_cyc_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0 and wb_dat_o=0.
REQ-026 SHALL abandon a reset asserted mid-transfer immediately, with no done pulse; cyc SHALL be low on the first cycle after reset.

Configuration
REQ-027 With WB_BLKCOPY_TIMEOUT_EN defined, SHALL count cycles with stb high and no ack or err.
REQ-028 With WB_BLKCOPY_TIMEOUT_EN defined, reaching TIMEOUT SHALL be treated exactly as wb_err_i; the counter clears in each gap state.
REQ-029 With WB_BLKCOPY_TIMEOUT_EN undefined, SHALL synthesize no counter and wait indefinitely for ack or err.

Structure
REQ-030 SHALL place the state encoding constants and the SEL_ALL=4'hF constant in shared package wb_pkg.
REQ-031 SHALL implement the timeout counter as sub-module wb_blkcopy_wdog, instantiated only under WB_BLKCOPY_TIMEOUT_EN.

Verification
REQ-032 With src=0x1000, dst=0x2000, len=3 and a 1-wait-state slave, the bench SHALL check reads at 0x1000/4/8 and writes at 0x2000/4/8 with matching data, done after the last write ack, and err=0.
REQ-033 With len=0, the bench SHALL check that cyc never asserts, done pulses 2 cycles after start, and busy is high for 1 cycle.
REQ-034 With src=0xFFFFFFFC and len=2, the bench SHALL check second read address 0x00000000.
REQ-035 With wb_err_i on the 2nd read of len=4, the bench SHALL check err=1, done pulse, exactly 1 write issued, and start ignored while busy.
REQ-036 With TIMEOUT=8, a slave that never acks and WB_BLKCOPY_TIMEOUT_EN defined, the bench SHALL check that stb drops after 8 cycles and that done and err assert.
REQ-037 With sys_rst_n pulled low during WR of len=5, the bench SHALL check all outputs 0 on the next cycle, and that a new start=1 with len=1 completes normally.
